// File: rtl/inta_sequencer_pkg.sv
// Shared types and constants for the INTA sequencer: FSM states, level widths,
// resolver result struct and the rotating-priority rank helper.
package inta_sequencer_pkg;

   localparam int NUM_IR = 8;
   localparam int LVL_W  = 3;

   typedef enum logic [2:0] {
      IDLE,
      INT_REQ,
      ACK1,
      WAIT2,
      ACK2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [LVL_W-1:0] level;
   } find_t;

   // Distance of a level from the head of the rotating order; 0 = highest priority.
   function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] level,
                                                  input logic [LVL_W-1:0] lowest);
      return level - lowest - LVL_W'(1);
   endfunction

endpackage

// File: rtl/inta_sequencer_priority_resolver.sv
// Rotating find-first: returns the first set bit of vec scanning from
// (lowest_prio+1) mod 8 upward and wrapping through lowest_prio.
module inta_sequencer_priority_resolver
   import inta_sequencer_pkg::*;
(
   input  logic [NUM_IR-1:0] vec,
   input  logic [LVL_W-1:0]  lowest_prio,
   output logic              valid,
   output logic [LVL_W-1:0]  level
);

   logic [LVL_W-1:0] idx;

   // Scan from the lowest-priority slot toward the head so the last hit wins.
   always_comb begin
      valid = 1'b0;
      level = '0;
      idx   = '0;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         idx = lowest_prio + LVL_W'(i + 1);
         if (vec[idx]) begin
            valid = 1'b1;
            level = idx;
         end
      end
   end

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt controller core: priority resolution against the ISR, INT/INTA
// two-pulse handshake, ISR ownership, EOI and priority rotation.
module inta_sequencer
   import inta_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        irr,
   input  logic [7:0]        imr,
   input  logic              inta_n,
   input  logic [4:0]        vector_base,
   input  logic              aeoi,
   input  logic              eoi_cmd,
   input  logic              eoi_specific,
   input  logic              eoi_rotate,
   input  logic [2:0]        eoi_level,
   input  logic              set_prio,
   output logic              int_out,
   output logic [7:0]        isr,
   output logic [2:0]        highest_priority,
   output logic              current_pulse,
   output logic              irr_clr,
   output logic [7:0]        data_out,
   output logic              data_oe
);

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inta_s, inta_d, fall, rise;

   logic [LVL_W-1:0]  lowest_prio, lowest_prio_n;
   logic              spurious, spurious_n;
   logic              int_out_n, current_pulse_n, irr_clr_n, data_oe_n;
   logic [LVL_W-1:0]  hp_n;
   logic [7:0]        data_out_n;
   logic [NUM_IR-1:0] isr_n, set_mask, clr_mask, req;
   find_t             cand, inserv;
   logic              pending;

   // inta_n is asynchronous; idle level is high so the chain resets to 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
         inta_d <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
         inta_d <= inta_s;
      end
   end

   assign inta_s = sync_q[SYNC_STAGES-1];
   assign fall   = inta_d & ~inta_s;
   assign rise   = ~inta_d & inta_s;

   assign req = irr & ~imr;

   inta_sequencer_priority_resolver u_req_res (
      .vec         (req),
      .lowest_prio (lowest_prio),
      .valid       (cand.valid),
      .level       (cand.level)
   );

   inta_sequencer_priority_resolver u_isr_res (
      .vec         (isr),
      .lowest_prio (lowest_prio),
      .valid       (inserv.valid),
      .level       (inserv.level)
   );

   // Fully nested: a request at the in-service level does not interrupt it.
   assign pending = cand.valid &&
                    (!inserv.valid ||
                     (prio_rank(cand.level, lowest_prio) < prio_rank(inserv.level, lowest_prio)));

   always_comb begin
      state_n         = state;
      int_out_n       = int_out;
      hp_n            = highest_priority;
      current_pulse_n = current_pulse;
      irr_clr_n       = 1'b0;
      data_out_n      = data_out;
      data_oe_n       = data_oe;
      spurious_n      = spurious;
      lowest_prio_n   = lowest_prio;
      set_mask        = '0;
      clr_mask        = '0;

      case (state)
         IDLE: begin
            int_out_n = pending;
            if (pending) state_n = INT_REQ;
         end
         INT_REQ: begin
            int_out_n = 1'b1;
            if (fall) begin
               state_n   = ACK1;
               int_out_n = 1'b0;
               if (pending) begin
                  hp_n                = cand.level;
                  set_mask[cand.level] = 1'b1;
                  irr_clr_n           = 1'b1;
                  spurious_n          = 1'b0;
               end else begin
                  hp_n       = LVL_W'(NUM_IR - 1);
                  spurious_n = 1'b1;
               end
            end
         end
         ACK1: begin
            if (rise) state_n = WAIT2;
         end
         WAIT2: begin
            if (fall) begin
               state_n         = ACK2;
               current_pulse_n = 1'b1;
               data_out_n      = {vector_base, highest_priority};
               data_oe_n       = 1'b1;
            end
         end
         ACK2: begin
            if (rise) begin
               state_n         = IDLE;
               current_pulse_n = 1'b0;
               data_oe_n       = 1'b0;
               if (aeoi && !spurious) begin
                  clr_mask[highest_priority] = 1'b1;
                  if (eoi_rotate) lowest_prio_n = highest_priority;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Software EOI may land in any state; an explicit command overrides AEOI rotation.
      if (eoi_cmd) begin
         if (eoi_specific) begin
            clr_mask[eoi_level] = 1'b1;
            if (eoi_rotate) lowest_prio_n = eoi_level;
         end else if (inserv.valid) begin
            clr_mask[inserv.level] = 1'b1;
            if (eoi_rotate) lowest_prio_n = inserv.level;
         end
      end else if (set_prio) begin
         lowest_prio_n = eoi_level;
      end

      isr_n = (isr & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         int_out          <= 1'b0;
         isr              <= '0;
         highest_priority <= '0;
         current_pulse    <= 1'b0;
         irr_clr          <= 1'b0;
         data_out         <= '0;
         data_oe          <= 1'b0;
         spurious         <= 1'b0;
         lowest_prio      <= LVL_W'(NUM_IR - 1);
      end else begin
         state            <= state_n;
         int_out          <= int_out_n;
         isr              <= isr_n;
         highest_priority <= hp_n;
         current_pulse    <= current_pulse_n;
         irr_clr          <= irr_clr_n;
         data_out         <= data_out_n;
         data_oe          <= data_oe_n;
         spurious         <= spurious_n;
         lowest_prio      <= lowest_prio_n;
      end
   end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: reset, basic ack, nesting, EOI/rotation,
// AEOI and spurious cycles with hand-computed expectations.
module tb_inta_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irr, imr;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       aeoi, eoi_cmd, eoi_specific, eoi_rotate, set_prio;
   logic [2:0] eoi_level;
   logic       int_out, current_pulse, irr_clr, data_oe;
   logic [7:0] isr, data_out;
   logic [2:0] highest_priority;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   inta_sequencer #(.SYNC_STAGES(2)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .irr              (irr),
      .imr              (imr),
      .inta_n           (inta_n),
      .vector_base      (vector_base),
      .aeoi             (aeoi),
      .eoi_cmd          (eoi_cmd),
      .eoi_specific     (eoi_specific),
      .eoi_rotate       (eoi_rotate),
      .eoi_level        (eoi_level),
      .set_prio         (set_prio),
      .int_out          (int_out),
      .isr              (isr),
      .highest_priority (highest_priority),
      .current_pulse    (current_pulse),
      .irr_clr          (irr_clr),
      .data_out         (data_out),
      .data_oe          (data_oe)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Two sync flops + edge detect + registered outputs = visible after 3 edges.
   task automatic inta_low();
      inta_n = 1'b0;
      tick(3);
   endtask

   task automatic inta_high();
      inta_n = 1'b1;
      tick(3);
   endtask

   task automatic clean_reset();
      reset_n = 1'b0; irr = '0; imr = '0; aeoi = 1'b0; inta_n = 1'b1;
      eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = '0; set_prio = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; irr = 8'hFF; imr = '0; aeoi = 1'b0; inta_n = 1'b1; vector_base = 5'b01000;
      eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = '0; set_prio = 1'b0;
      tick(3);
      total_cnt++;
      if ({int_out, isr, highest_priority, current_pulse, irr_clr, data_out, data_oe} !== 23'd0)
         $display("FAIL reset_outputs got int=%b isr=%h hp=%0d cp=%b clr=%b dout=%h oe=%b exp all 0",
                  int_out, isr, highest_priority, current_pulse, irr_clr, data_out, data_oe);
      else pass_cnt++;
      reset_n = 1'b1;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL reset_release_int got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (highest_priority !== 3'd0) $display("FAIL reset_prio_ir0 got %0d exp 0", highest_priority);
      else pass_cnt++;
      total_cnt++;
      if (isr !== 8'h01) $display("FAIL reset_ack_isr got %h exp 01", isr); else pass_cnt++;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({int_out, isr, highest_priority, irr_clr, data_oe} !== 14'd0)
         $display("FAIL reset_midcycle got int=%b isr=%h hp=%0d clr=%b oe=%b exp all 0",
                  int_out, isr, highest_priority, irr_clr, data_oe);
      else pass_cnt++;
      clean_reset();
   endtask

   task automatic test_basic_ack();
      clean_reset();
      irr = 8'h20;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL basic_int got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (irr_clr !== 1'b1) $display("FAIL basic_irr_clr got %b exp 1", irr_clr); else pass_cnt++;
      total_cnt++;
      if (highest_priority !== 3'd5) $display("FAIL basic_hp got %0d exp 5", highest_priority);
      else pass_cnt++;
      total_cnt++;
      if (isr !== 8'h20) $display("FAIL basic_isr got %h exp 20", isr); else pass_cnt++;
      total_cnt++;
      if ({int_out, data_oe} !== 2'b00) $display("FAIL basic_ack1_outs got %b%b exp 00", int_out, data_oe);
      else pass_cnt++;
      tick(1);
      total_cnt++;
      if (irr_clr !== 1'b0) $display("FAIL basic_irr_clr_pulse got %b exp 0", irr_clr); else pass_cnt++;
      irr = 8'h00;
      inta_high();
      total_cnt++;
      if (data_oe !== 1'b0) $display("FAIL basic_oe_between got %b exp 0", data_oe); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (data_out !== 8'h45) $display("FAIL basic_vector got %h exp 45", data_out); else pass_cnt++;
      total_cnt++;
      if ({data_oe, current_pulse} !== 2'b11)
         $display("FAIL basic_pulse2 got oe=%b cp=%b exp 11", data_oe, current_pulse);
      else pass_cnt++;
      inta_high();
      total_cnt++;
      if ({data_oe, current_pulse} !== 2'b00)
         $display("FAIL basic_end got oe=%b cp=%b exp 00", data_oe, current_pulse);
      else pass_cnt++;
      total_cnt++;
      if (isr !== 8'h20) $display("FAIL basic_isr_held got %h exp 20", isr); else pass_cnt++;
   endtask

   task automatic test_nesting();
      clean_reset();
      irr = 8'h04;
      tick(2);
      inta_low(); irr = 8'h00; inta_high(); inta_low(); inta_high();
      total_cnt++;
      if (isr !== 8'h04) $display("FAIL nest_setup_isr got %h exp 04", isr); else pass_cnt++;
      irr = 8'h10;
      tick(3);
      total_cnt++;
      if (int_out !== 1'b0) $display("FAIL nest_lower_blocked got %b exp 0", int_out); else pass_cnt++;
      imr = 8'h02; irr = 8'h12;
      tick(3);
      total_cnt++;
      if (int_out !== 1'b0) $display("FAIL nest_masked got %b exp 0", int_out); else pass_cnt++;
      imr = 8'h00;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL nest_higher_int got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (highest_priority !== 3'd1) $display("FAIL nest_hp got %0d exp 1", highest_priority);
      else pass_cnt++;
      total_cnt++;
      if (isr !== 8'h06) $display("FAIL nest_isr got %h exp 06", isr); else pass_cnt++;
      irr = 8'h10;
      inta_high(); inta_low(); inta_high();
   endtask

   task automatic test_eoi_rotate();
      // Starts from isr=06, lowest_prio=7, irr=10, state IDLE.
      eoi_cmd = 1'b1; eoi_specific = 1'b0; eoi_rotate = 1'b1;
      tick(1);
      eoi_cmd = 1'b0; eoi_rotate = 1'b0;
      total_cnt++;
      if (isr !== 8'h04) $display("FAIL eoi_ns_isr got %h exp 04", isr); else pass_cnt++;
      irr = 8'h03;
      tick(3);
      total_cnt++;
      if (int_out !== 1'b0) $display("FAIL eoi_rotated_order got %b exp 0", int_out); else pass_cnt++;
      eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
      tick(1);
      eoi_cmd = 1'b0; eoi_specific = 1'b0;
      total_cnt++;
      if (isr !== 8'h00) $display("FAIL eoi_spec_isr got %h exp 00", isr); else pass_cnt++;
      irr = 8'h83;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL eoi_reint got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (highest_priority !== 3'd7) $display("FAIL eoi_rot_hp7 got %0d exp 7", highest_priority);
      else pass_cnt++;
      irr = 8'h03;
      inta_high(); inta_low();
      total_cnt++;
      if (data_out !== 8'h47) $display("FAIL eoi_rot_vector got %h exp 47", data_out); else pass_cnt++;
      inta_high();
      eoi_level = 3'd0; set_prio = 1'b1;
      tick(1);
      set_prio = 1'b0;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL setprio_int got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if ({highest_priority, isr} !== {3'd1, 8'h82})
         $display("FAIL setprio_ack got hp=%0d isr=%h exp hp=1 isr=82", highest_priority, isr);
      else pass_cnt++;
      irr = 8'h01;
      inta_high(); inta_low(); inta_high();
   endtask

   task automatic test_aeoi();
      clean_reset();
      aeoi = 1'b1; irr = 8'h01;
      tick(2);
      inta_low();
      total_cnt++;
      if (isr !== 8'h01) $display("FAIL aeoi_isr_set got %h exp 01", isr); else pass_cnt++;
      irr = 8'h00;
      inta_high(); inta_low(); inta_high();
      total_cnt++;
      if (isr !== 8'h00) $display("FAIL aeoi_isr_clr got %h exp 00", isr); else pass_cnt++;
      irr = 8'h04;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL aeoi_back_idle got %b exp 1", int_out); else pass_cnt++;
      clean_reset();
   endtask

   task automatic test_spurious();
      clean_reset();
      irr = 8'h08;
      tick(2);
      irr = 8'h00;
      tick(2);
      total_cnt++;
      if (int_out !== 1'b1) $display("FAIL spur_int_held got %b exp 1", int_out); else pass_cnt++;
      inta_low();
      total_cnt++;
      if (highest_priority !== 3'd7) $display("FAIL spur_hp got %0d exp 7", highest_priority);
      else pass_cnt++;
      total_cnt++;
      if ({irr_clr, isr, int_out} !== 10'd0)
         $display("FAIL spur_ack1 got clr=%b isr=%h int=%b exp 0/00/0", irr_clr, isr, int_out);
      else pass_cnt++;
      inta_high(); inta_low();
      total_cnt++;
      if ({data_oe, data_out} !== {1'b1, 8'h47})
         $display("FAIL spur_vector got oe=%b dout=%h exp 1/47", data_oe, data_out);
      else pass_cnt++;
      inta_high();
      total_cnt++;
      if (data_oe !== 1'b0) $display("FAIL spur_end_oe got %b exp 0", data_oe); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_ack();
      test_nesting();
      test_eoi_rotate();
      test_aeoi();
      test_spurious();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
